// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code run controller and its shadow checker.
// Contents: controller state encoding, Gray counter width, binary-to-Gray helper.
package gray_pkg;

  localparam int unsigned GRAY_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Reflected binary Gray code of a counter value.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_shadow.sv
// Shadow binary model of the 3-bit Gray counter, used to cross-check the counter.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   clr          clear shadow, wrap_seen and Wraps (start of a run)
//   inc          counter enable issued this cycle
//   GrayIn       Gray output returned by the counter
//   OvfIn        sticky overflow returned by the counter
//   Wraps        saturating count of 7->0 wraps this run
//   mismatch_c   combinational: counter disagrees with the shadow
module gray_shadow
  import gray_pkg::*;
#(
  parameter int unsigned WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [GRAY_W-1:0] GrayIn,
  input  logic              OvfIn,
  output logic [WRAP_W-1:0] Wraps,
  output logic              mismatch_c
);

  localparam logic [GRAY_W-1:0] SHADOW_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAPS_MAX  = '1;

  logic [GRAY_W-1:0] shadow_q;
  logic              wrap_seen_q;

  // Shadow counter; wrap_seen tracks the counter's sticky overflow independently
  // of Wraps, which stops counting once saturated.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      shadow_q    <= '0;
      wrap_seen_q <= 1'b0;
      Wraps       <= '0;
    end else if (inc) begin
      shadow_q <= shadow_q + GRAY_W'(1);
      if (shadow_q == SHADOW_MAX) begin
        wrap_seen_q <= 1'b1;
        if (Wraps != WRAPS_MAX) begin
          Wraps <= Wraps + WRAP_W'(1);
        end
      end
    end
  end

  assign mismatch_c = (GrayIn != bin2gray(shadow_q)) || (OvfIn != wrap_seen_q);

endmodule

// File: rtl/gray_run_ctrl.sv
// Run sequencer for the 3-bit Gray counter: clears it, issues a commanded number
// of enable pulses, and checks every returned value against a shadow model.
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Start, Steps      run request and enable-pulse count (accepted in IDLE)
//   Stop              abort request (honoured in RUN)
//   GrayIn, OvfIn     counter Output / Overflow
//   CntEn, CntReset   counter En / Reset (combinational)
//   Busy, Done        run in progress / one-cycle end-of-run pulse
//   Aborted, Err      how the last run ended
//   Wraps, Remaining  wraps seen in last run / enable pulses still to issue
module gray_run_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned STEP_W = 8,
  parameter int unsigned WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [STEP_W-1:0] Steps,
  input  logic              Stop,
  input  logic [GRAY_W-1:0] GrayIn,
  input  logic              OvfIn,
  output logic              CntEn,
  output logic              CntReset,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic              Err,
  output logic [WRAP_W-1:0] Wraps,
  output logic [STEP_W-1:0] Remaining
);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] remaining_d;
  logic              aborted_d, err_d, busy_d, done_d;
  logic              cnt_en_c, shadow_clr_c, mismatch_raw_c, mismatch_c;

  gray_shadow #(.WRAP_W(WRAP_W)) u_shadow (
    .Clk        (Clk),
    .Reset      (Reset),
    .clr        (shadow_clr_c),
    .inc        (cnt_en_c),
    .GrayIn     (GrayIn),
    .OvfIn      (OvfIn),
    .Wraps      (Wraps),
    .mismatch_c (mismatch_raw_c)
  );

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      Remaining <= '0;
      Aborted   <= 1'b0;
      Err       <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      Remaining <= remaining_d;
      Aborted   <= aborted_d;
      Err       <= err_d;
      Busy      <= busy_d;
      Done      <= done_d;
    end
  end

  // Next state, next registered outputs and counter enable.
  always_comb begin
    state_d      = state_q;
    remaining_d  = Remaining;
    aborted_d    = Aborted;
    err_d        = Err;
    cnt_en_c     = 1'b0;
    shadow_clr_c = 1'b0;
    mismatch_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          remaining_d  = Steps;
          aborted_d    = 1'b0;
          err_d        = 1'b0;
          shadow_clr_c = 1'b1;
          state_d      = ST_CLR;
        end
      end

      ST_CLR: state_d = ST_RUN;

      ST_RUN: begin
        mismatch_c = mismatch_raw_c;
        // Reset gating keeps the shadow from stepping while the counter is held.
        cnt_en_c   = !Reset && (Remaining != '0) && !Stop && !mismatch_c;
        if (cnt_en_c) begin
          remaining_d = Remaining - STEP_W'(1);
        end
        // Exit on the cycle issuing the last pulse so Done lands at Steps+2.
        if (mismatch_c) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (Stop) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (Remaining <= STEP_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        mismatch_c = mismatch_raw_c;
        // Keep Err and Aborted mutually exclusive for a run.
        if (mismatch_c && !Aborted) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CLR) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign CntEn    = cnt_en_c;
  assign CntReset = Reset || (state_q == ST_CLR);

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Self-checking bench for gray_run_ctrl, with a behavioural Gray counter attached.
module tb_gray_run_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Stop, OvfIn;
  logic [7:0] Steps;
  logic [2:0] GrayIn;
  logic       CntEn, CntReset, Busy, Done, Aborted, Err;
  logic [3:0] Wraps;
  logic [7:0] Remaining;

  gray_run_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Steps(Steps), .Stop(Stop),
    .GrayIn(GrayIn), .OvfIn(OvfIn), .CntEn(CntEn), .CntReset(CntReset),
    .Busy(Busy), .Done(Done), .Aborted(Aborted), .Err(Err),
    .Wraps(Wraps), .Remaining(Remaining)
  );

  always #5 Clk = ~Clk;

  // Behavioural 3-bit Gray counter with sticky overflow; flip corrupts bit0.
  logic [2:0] cnt;
  logic       ovf;
  logic       flip;
  always @(posedge Clk) begin
    if (CntReset) begin
      cnt <= 3'd0;
      ovf <= 1'b0;
    end else if (CntEn) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) ovf <= 1'b1;
    end
  end
  assign GrayIn = (cnt ^ (cnt >> 1)) ^ {2'b00, flip};
  assign OvfIn  = ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected-run description produced by the model in run_case.
  bit         active = 1'b0;
  int         cur_c, m_n, m_k, m_last;
  bit         m_stop, m_err;
  int         done_at;
  logic [2:0] gray_log [0:255];

  // Cycle c: 1 = cycle after accept. Enables fill cycles 2..k+1, Done at m_last.
  always @(negedge Clk) begin
    int c, e, w;
    if (active) begin
      c = cur_c;
      e = (c < 2) ? 0 : ((c - 2 > m_k) ? m_k : c - 2);
      w = (e / 8 > 15) ? 15 : e / 8;
      chk("busy",      int'(Busy),      int'(c <= m_last - 1));
      chk("done",      int'(Done),      int'(c == m_last));
      chk("cnt_en",    int'(CntEn),     int'(c >= 2 && c <= m_k + 1));
      chk("cnt_reset", int'(CntReset),  int'(c == 1));
      chk("remaining", int'(Remaining), m_n - e);
      chk("wraps",     int'(Wraps),     w);
      chk("aborted",   int'(Aborted),   int'(m_stop && c >= m_last));
      chk("err",       int'(Err),       int'(m_err && c >= m_last));
      gray_log[c] = GrayIn;
      if (Done && done_at < 0) done_at = c;
    end
  end

  // sr/fr: RUN cycle (1-based) carrying Stop / corrupted GrayIn; bs: cycle of an
  // extra Start that must be ignored; ss: assert Stop alongside the accepted Start.
  task automatic run_case(input int n, input int sr, input int fr, input int bs, input bit ss);
    int er, k;
    bit bstop, berr;
    er = (n == 0) ? 1 : n;
    bstop = 1'b0;
    berr  = 1'b0;
    if (sr != 0 && sr <= er) begin er = sr; bstop = 1'b1; end
    if (fr != 0 && fr <= er) begin er = fr; berr = 1'b1; bstop = 1'b0; end
    k = (bstop || berr) ? er - 1 : n;

    Steps = 8'(n);
    Start = 1'b1;
    Stop  = ss;
    @(posedge Clk); #1;
    Start = 1'b0;
    Stop  = 1'b0;
    Steps = 8'hA5;
    m_n = n; m_k = k; m_last = er + 2; m_stop = bstop; m_err = berr;
    done_at = -1;
    for (int c = 1; c <= er + 4; c++) begin
      cur_c  = c;
      Stop   = (sr != 0 && c == sr + 1);
      flip   = (fr != 0 && c == fr + 1);
      Start  = (bs != 0 && c == bs);
      active = 1'b1;
      @(posedge Clk); #1;
    end
    active = 1'b0;
    Stop   = 1'b0;
    flip   = 1'b0;
    Start  = 1'b0;
  endtask

  logic [2:0] seq5 [0:5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Steps = 8'd0; flip = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_cnt_reset", int'(CntReset), 1);
    chk("rst_busy",      int'(Busy), 0);
    chk("rst_done",      int'(Done), 0);
    chk("rst_remaining", int'(Remaining), 0);
    chk("rst_wraps",     int'(Wraps), 0);
    chk("rst_flags",     int'({Aborted, Err, CntEn}), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Basic run of 5.
    run_case(5, 0, 0, 0, 1'b0);
    chk("run5_done_cycle", done_at, 7);
    for (int i = 0; i < 6; i++) chk("run5_gray_seq", int'(gray_log[i + 2]), int'(seq5[i]));
    chk("run5_remaining", int'(Remaining), 0);
    chk("run5_wraps", int'(Wraps), 0);

    // One wrap, plus a Start during RUN that must be ignored.
    run_case(10, 0, 0, 4, 1'b0);
    chk("wrap_done_cycle", done_at, 12);
    chk("wrap_wraps", int'(Wraps), 1);
    chk("wrap_final_gray", int'(GrayIn), 3);
    chk("wrap_err", int'(Err), 0);

    // Abort in the 3rd RUN cycle.
    run_case(20, 3, 0, 0, 1'b0);
    chk("abort_done_cycle", done_at, 5);
    chk("abort_flag", int'(Aborted), 1);
    chk("abort_remaining", int'(Remaining), 18);

    // Mismatch in the 4th RUN cycle; Start+Stop together at accept.
    run_case(6, 0, 4, 0, 1'b1);
    chk("mm_done_cycle", done_at, 6);
    chk("mm_err", int'(Err), 1);
    chk("mm_aborted_cleared", int'(Aborted), 0);
    chk("mm_remaining", int'(Remaining), 3);

    // Steps=0 with a Start in DONE that must be ignored.
    run_case(0, 0, 0, 3, 1'b0);
    chk("zero_done_cycle", done_at, 3);
    chk("zero_err_cleared", int'(Err), 0);
    chk("zero_idle", int'(Busy), 0);

    // Saturating wrap count.
    run_case(200, 0, 0, 0, 1'b0);
    chk("sat_wraps", int'(Wraps), 15);
    chk("sat_done_cycle", done_at, 202);

    // Reset asserted in the 4th RUN cycle, held two cycles.
    Steps = 8'd8; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int c = 1; c < 5; c++) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    #4;
    chk("mid_rst_cnt_reset_now", int'(CntReset), 1);
    @(posedge Clk); #1;
    #4;
    chk("mid_rst_cnt_reset", int'(CntReset), 1);
    chk("mid_rst_busy", int'(Busy), 0);
    chk("mid_rst_done", int'(Done), 0);
    chk("mid_rst_remaining", int'(Remaining), 0);
    chk("mid_rst_wraps", int'(Wraps), 0);
    chk("mid_rst_flags", int'({Aborted, Err, CntEn}), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("post_rst_done", int'(Done), 0);
      chk("post_rst_busy", int'(Busy), 0);
      @(posedge Clk); #1;
    end
    run_case(3, 0, 0, 0, 1'b0);
    chk("after_rst_done_cycle", done_at, 5);
    chk("after_rst_err", int'(Err), 0);
    chk("after_rst_gray", int'(GrayIn), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
